led_blink_arbiter: RTL and testbench
====================================

// Module: led_blink_arbiter
// PURPOSE
//  Shares the single board LED among NREQ requesters, each asking for a burst of N blinks.
//  Round-robin arbiter plus a blink sequencer (IDLE/ON/OFF/GAP) timed by an internal prescaler.
//  Sits between status sources (heartbeat, error, user) and the LED pin on the 50 MHz clock.
// PARAMETERS
//  NREQ      4           number of requesters (fixed 4; grant_id is 2 bits)
//  PRESCALE  12_500_000  clk cycles per tick (0.25 s at 50 MHz); must be >= 1
//  ON_TICKS  1           ticks LED is on per blink; must be >= 1
//  OFF_TICKS 1           ticks LED is off after each blink; must be >= 1
//  GAP_TICKS 4           ticks of LED-off spacer after a burst, before ack; must be >= 1
// PORTS
//  clk        in   1       50 MHz clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req        in   NREQ    level request per requester, held until its ack
//  blink_cnt  in   4*NREQ  requested blink count for requester i in [4*i+3:4*i], 0..15
//  ack        out  NREQ    one-cycle done pulse to the served requester
//  busy       out  1       high whenever state != IDLE
//  grant_id   out  2       index of requester being served; valid while busy
//  led        out  1       LED drive, registered
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, led=0, ack=0, busy=0, grant_id=0.
//   Round-robin pointer last=NREQ-1, so req[0] wins the first arbitration.
//   Cycle timer and blink counter are cleared.
//  Release: all outputs are registered; release of rst_n needs no extra sync cycle.
//  IDLE: when any req bit is high, choose the first set bit searching from last+1 upward, wrapping.
//   Next edge: grant_id=winner, last=winner, busy=1.
//   blink_cnt of the winner is sampled once at this edge; later changes are ignored.
//   Count>0: enter ON with led=1 on the same edge (1-cycle req->led latency).
//   Count==0: enter GAP directly; led stays 0.
//  Timing: the cycle timer clears on every state entry.
//   Each state lasts exactly ticks*PRESCALE cycles: ON uses ON_TICKS, OFF uses OFF_TICKS, GAP uses GAP_TICKS.
//   Timer width is clog2(max(ON,OFF,GAP)*PRESCALE+1); it has no free-running phase.
//  ON -> OFF (led=0). OFF decrements the remaining count:
//   remaining count > 0 -> ON (led=1); remaining count == 0 -> GAP.
//  GAP: led=0. In its last cycle ack[grant_id]=1 for exactly one cycle, then next state is IDLE.
//   busy drops to 0 on that same edge.
//  Burst duration: count*(ON_TICKS+OFF_TICKS)*PRESCALE + GAP_TICKS*PRESCALE cycles, from grant to IDLE.
//  Requester drops req mid-burst: the burst still completes and ack is still pulsed (no abort).
//  Requester holds req after ack: treated as a new request. The pointer has advanced, so other
//   pending requesters are served first.
//  Arbitration happens only in IDLE, so new requests during a burst wait.
//   At least one IDLE cycle separates consecutive bursts (led=0).
//  Simultaneous requests in IDLE: only the winner is granted; the others keep waiting with no ack.
//  Reset mid-burst: immediate return to the reset values; no ack is issued for the aborted burst.
//  ack is never asserted for a requester other than grant_id, and never for two requesters at once.
// CONFIGURATION
//  LED_BLINK_STRICT_PRIO_EN defined: fixed priority, lowest index wins every arbitration.
//   The last pointer is unused and a held req[0] can starve the others.
//  LED_BLINK_STRICT_PRIO_EN undefined (default): round-robin as described above.
//  Timing, handshake and outputs are identical in both builds.
// TESTING  (PRESCALE=4, ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=2)
//  1 Reset: rst_n=0 asserted mid-burst -> led=0, busy=0, ack=0 in the same cycle.
//    After release, a req[1] burst is served normally.
//  2 Single burst: req[0]=1 with cnt=3 -> led pattern 4 high/4 low, three times, then 8 low.
//    ack[0] pulses once, 32 cycles after grant; busy is high for those 32 cycles.
//  3 Zero count: req[2]=1 with cnt=0 -> led stays 0, grant_id=2, busy for 8 cycles, ack[2] once.
//  4 Round-robin: req=4'b1111 held, each with cnt=1 and re-raised after ack.
//    Grants go 0,1,2,3,0; each burst lasts 16 cycles, with 1 idle cycle between bursts.
//  5 Mid-burst change: req[1]=1 with cnt=2; after grant drop req[1] and set cnt to 9.
//    Still exactly 2 blinks, then ack[1].
//  6 Strict priority build: req[0] held high and re-raised, plus req[3]=1.
//    req[3] is never granted; in the default build grants alternate 0,3.

Source files
------------

// File: rtl/led_blink_arbiter.sv
// Shares one LED among NREQ requesters: arbiter plus IDLE/ON/OFF/GAP blink sequencer.
// Define LED_BLINK_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module led_blink_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned PRESCALE  = 12_500_000,
  parameter int unsigned ON_TICKS  = 1,
  parameter int unsigned OFF_TICKS = 1,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] blink_cnt,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              led
);

  localparam int unsigned OnCyc   = ON_TICKS * PRESCALE;
  localparam int unsigned OffCyc  = OFF_TICKS * PRESCALE;
  localparam int unsigned GapCyc  = GAP_TICKS * PRESCALE;
  localparam int unsigned MaxOnOff = (OnCyc > OffCyc) ? OnCyc : OffCyc;
  localparam int unsigned MaxCyc  = (MaxOnOff > GapCyc) ? MaxOnOff : GapCyc;
  localparam int unsigned TW      = $clog2(MaxCyc + 1);

  localparam logic [TW-1:0] OnLast  = TW'(OnCyc - 1);
  localparam logic [TW-1:0] OffLast = TW'(OffCyc - 1);
  localparam logic [TW-1:0] GapLast = TW'(GapCyc - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic            led_q, led_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic [1:0] winner;
  logic [3:0] win_cnt;

`ifdef LED_BLINK_STRICT_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) winner = 2'(i);
    end
  end
`else
  // Search starts one past the last winner and wraps.
  always_comb begin
    logic found;
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = 2'(idx);
      end
    end
  end
`endif

  assign win_cnt = blink_cnt[4*winner +: 4];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (|req) begin
          grant_d = winner;
          last_d  = winner;
          cnt_d   = win_cnt;
          state_d = (win_cnt != 4'd0) ? StOn : StGap;
        end
      end
      StOn: begin
        if (timer_q == OnLast) begin
          timer_d = '0;
          state_d = StOff;
        end
      end
      StOff: begin
        if (timer_q == OffLast) begin
          timer_d = '0;
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q > 4'd1) ? StOn : StGap;
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    led_d = (state_d == StOn);
    ack_d = '0;
    if (state_d == StGap && timer_d == GapLast) ack_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= 2'(NREQ - 1);
      led_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign grant_id = grant_q;
  assign led      = led_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with PRESCALE=4, ON=1, OFF=1, GAP=2 ticks.
module tb_led_blink_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] blink_cnt;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        led;

  int checks = 0;
  int errors = 0;

  led_blink_arbiter #(
    .NREQ(4), .PRESCALE(4), .ON_TICKS(1), .OFF_TICKS(1), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .blink_cnt(blink_cnt),
    .ack(ack), .busy(busy), .grant_id(grant_id), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Blink period is 8 cycles (4 on, 4 off); gap is 8 cycles; ack in the final cycle.
  task automatic run_burst(input int id, input int cnt, input int first_c,
                           input logic [3:0] drop);
    int dur;
    logic exp_led;
    dur = cnt * 8 + 8;
    for (int c = first_c; c <= dur; c++) begin
      @(negedge clk);
      exp_led = (c <= cnt * 8) && (((c - 1) % 8) < 4);
      chk($sformatf("led id%0d c%0d", id, c), 32'(led), 32'(exp_led));
      chk($sformatf("busy id%0d c%0d", id, c), 32'(busy), 32'd1);
      chk($sformatf("gid id%0d c%0d", id, c), 32'(grant_id), 32'(id));
      chk($sformatf("ack id%0d c%0d", id, c), 32'(ack),
          (c == dur) ? (32'd1 << id) : 32'd0);
      if (c == dur) req = req & ~drop;
    end
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " led"}, 32'(led), 32'd0);
    chk({tag, " ack"}, 32'(ack), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    blink_cnt = '0;

    // Reset values
    @(negedge clk);
    chk("rst led", 32'(led), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single burst, count 3
    blink_cnt = 16'h0003;
    req       = 4'b0001;
    run_burst(0, 3, 1, 4'b0001);
    idle_chk("single post");

    // Zero count on requester 2
    blink_cnt = 16'h0000;
    req       = 4'b0100;
    run_burst(2, 0, 1, 4'b0100);
    idle_chk("zero post");

    // Round-robin with all requests held
    do_reset();
    blink_cnt = 16'h1111;
    req       = 4'b1111;
    run_burst(0, 1, 1, 4'b0000);
    idle_chk("rr gap0");
    run_burst(1, 1, 1, 4'b0000);
    idle_chk("rr gap1");
    run_burst(2, 1, 1, 4'b0000);
    idle_chk("rr gap2");
    run_burst(3, 1, 1, 4'b0000);
    idle_chk("rr gap3");
    run_burst(0, 1, 1, 4'b1111);
    idle_chk("rr end");

    // Mid-burst drop of req and count change
    blink_cnt = 16'h0020;
    req       = 4'b0010;
    @(negedge clk);
    chk("mid c1 led", 32'(led), 32'd1);
    chk("mid c1 gid", 32'(grant_id), 32'd1);
    req       = 4'b0000;
    blink_cnt = 16'h0090;
    run_burst(1, 2, 2, 4'b0000);
    idle_chk("mid post");
    idle_chk("mid no regrant");

    // Reset asserted mid-burst while led is on
    blink_cnt = 16'h5000;
    req       = 4'b1000;
    repeat (3) @(negedge clk);
    chk("midrst pre led", 32'(led), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst led", 32'(led), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ack", 32'(ack), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    blink_cnt = 16'h0010;
    req       = 4'b0010;
    run_burst(1, 1, 1, 4'b0010);
    idle_chk("after rst post");

    // req[0] and req[3] held together
    do_reset();
    blink_cnt = 16'h1001;
    req       = 4'b1001;
`ifdef LED_BLINK_STRICT_PRIO_EN
    run_burst(0, 1, 1, 4'b0000);
    idle_chk("prio gap0");
    run_burst(0, 1, 1, 4'b0000);
    idle_chk("prio gap1");
    run_burst(0, 1, 1, 4'b1001);
`else
    run_burst(0, 1, 1, 4'b0000);
    idle_chk("prio gap0");
    run_burst(3, 1, 1, 4'b0000);
    idle_chk("prio gap1");
    run_burst(0, 1, 1, 4'b1001);
`endif
    idle_chk("prio end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
